tlp_probe_capture: RTL and testbench

- Passive snoop stage directly upstream of the 256-bit SignalTap capture wrapper.
- Watches the 128-bit Avalon-ST RX TLP stream without driving it.
- Tracks packet framing and latches TLP header DW0/DW1.
- Packs data, timestamp, counters and status into the 256-bit probe word. That word feeds the capture instance's data/trigger input.

---
 rtl/tlp_probe_pkg.sv | 47 ++++
 rtl/tlp_frame_fsm.sv | 105 ++++++++++
 rtl/tlp_probe_capture.sv | 132 +++++++++++++
 tb/tb_tlp_probe_capture.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tlp_probe_pkg.sv
// Shared constants for the TLP probe capture stage: FSM encodings,
// counter widths, probe word field positions and saturating helpers.
package tlp_probe_pkg;

    localparam int BEAT_W     = 8;
    localparam int PKT_W      = 16;
    localparam int ERRC_W     = 4;
    localparam int STATE_W    = 2;
    localparam int HDR_W      = 64;
    localparam int HDR_KEEP_W = 60;

    // Framing FSM encodings; 2'd3 is never entered.
    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_IN_PKT = 2'd1;
    localparam logic [STATE_W-1:0] ST_ERR    = 2'd2;

    // Probe word field positions.
    localparam int DATA_LSB   = 0;
    localparam int DATA_MSB   = 127;
    localparam int TS_LSB     = 128;
    localparam int TS_MSB     = 159;
    localparam int PKT_LSB    = 160;
    localparam int PKT_MSB    = 175;
    localparam int BEAT_LSB   = 176;
    localparam int BEAT_MSB   = 183;
    localparam int SOP_BIT    = 184;
    localparam int EOP_BIT    = 185;
    localparam int VALID_BIT  = 186;
    localparam int READY_BIT  = 187;
    localparam int XFER_BIT   = 188;
    localparam int STATE_LSB  = 189;
    localparam int STATE_MSB  = 190;
    localparam int STICKY_BIT = 191;
    localparam int ERRC_LSB   = 192;
    localparam int ERRC_MSB   = 195;
    localparam int HDR_LSB    = 196;
    localparam int HDR_MSB    = 255;

    function automatic logic [BEAT_W-1:0] sat_inc8(input logic [BEAT_W-1:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [ERRC_W-1:0] sat_inc4(input logic [ERRC_W-1:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/tlp_frame_fsm.sv
// Packet framing tracker for the snooped RX stream: state, beat index
// and a registered one-cycle pulse per framing error. Next-state values
// are exported so the probe word can show post-edge values.
module tlp_frame_fsm
    import tlp_probe_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_xfer,
    input  logic               i_sop,
    input  logic               i_eop,
    output logic [STATE_W-1:0] o_state_nxt,
    output logic [BEAT_W-1:0]  o_beat_nxt,
    output logic               o_err_evt,
    output logic               o_legal_eop,
    output logic               o_err_pulse
);

    logic [STATE_W-1:0] r_state;
    logic [BEAT_W-1:0]  r_beat;
    logic               r_err_pulse;
    logic [STATE_W-1:0] w_state_nxt;
    logic [BEAT_W-1:0]  w_beat_nxt;
    logic               w_err_evt;
    logic               w_legal_eop;

    // Next-state decode; an error is any entry into ERR, including a self-loop.
    always_comb begin
        w_state_nxt = r_state;
        w_err_evt   = 1'b0;
        w_legal_eop = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_xfer && i_sop) begin
                    if (i_eop) begin
                        w_state_nxt = ST_IDLE;
                        w_legal_eop = 1'b1;
                    end else begin
                        w_state_nxt = ST_IN_PKT;
                    end
                end else if (i_xfer) begin
                    w_state_nxt = ST_ERR;
                    w_err_evt   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IN_PKT: begin
                if (i_xfer && i_sop) begin
                    w_state_nxt = ST_ERR;
                    w_err_evt   = 1'b1;
                end else if (i_xfer && i_eop) begin
                    w_state_nxt = ST_IDLE;
                    w_legal_eop = 1'b1;
                end else begin
                    w_state_nxt = ST_IN_PKT;
                end
            end
            ST_ERR: begin
                if (i_xfer && i_sop) begin
                    w_state_nxt = i_eop ? ST_IDLE : ST_IN_PKT;
                end else if (i_xfer) begin
                    w_state_nxt = ST_ERR;
                    w_err_evt   = 1'b1;
                end else begin
                    w_state_nxt = ST_ERR;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Beat index: restarts on any SOP transfer, counts later in-packet beats.
    always_comb begin
        if (i_xfer && i_sop) begin
            w_beat_nxt = 8'd0;
        end else if (i_xfer && (r_state == ST_IN_PKT)) begin
            w_beat_nxt = sat_inc8(r_beat);
        end else begin
            w_beat_nxt = r_beat;
        end
    end

    // State, beat index and error pulse registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_beat      <= 8'd0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat      <= w_beat_nxt;
            r_err_pulse <= w_err_evt;
        end
    end

    assign o_state_nxt = w_state_nxt;
    assign o_beat_nxt  = w_beat_nxt;
    assign o_err_evt   = w_err_evt;
    assign o_legal_eop = w_legal_eop;
    assign o_err_pulse = r_err_pulse;

endmodule

// File: rtl/tlp_probe_capture.sv
// Passive snoop of the 128-bit RX TLP stream. Builds the 256-bit probe
// word (data, timestamp, counters, framing status, header) that feeds the
// capture instance. Counter/state fields carry post-edge values; the
// timestamp is the value of the cycle in which the data was sampled.
module tlp_probe_capture
    import tlp_probe_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int TS_W    = 32,
    parameter int PROBE_W = 256
)
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [DATA_W-1:0]  i_rx_st_data,
    input  logic               i_rx_st_sop,
    input  logic               i_rx_st_eop,
    input  logic               i_rx_st_valid,
    input  logic               i_rx_st_ready,
    input  logic               i_freeze,
    input  logic               i_clr_stats,
    output logic [PROBE_W-1:0] o_probe_data,
    output logic               o_err_pulse
);

    logic               w_xfer;
    logic [STATE_W-1:0] w_state_nxt;
    logic [BEAT_W-1:0]  w_beat_nxt;
    logic               w_err_evt;
    logic               w_legal_eop;
    logic [PKT_W-1:0]   r_pkt_cnt;
    logic [PKT_W-1:0]   w_pkt_cnt_nxt;
    logic [ERRC_W-1:0]  r_err_cnt;
    logic [ERRC_W-1:0]  w_err_cnt_nxt;
    logic               r_sticky;
    logic               w_sticky_nxt;
    logic [HDR_W-1:0]   r_hdr;
    logic [HDR_W-1:0]   w_hdr_nxt;
    logic [TS_W-1:0]    r_ts;
    logic [PROBE_W-1:0] r_probe;
    logic [PROBE_W-1:0] w_probe_nxt;
    logic               w_unused_hdr;

    assign w_xfer = i_rx_st_valid & i_rx_st_ready;

    tlp_frame_fsm u_fsm (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_xfer      (w_xfer),
        .i_sop       (i_rx_st_sop),
        .i_eop       (i_rx_st_eop),
        .o_state_nxt (w_state_nxt),
        .o_beat_nxt  (w_beat_nxt),
        .o_err_evt   (w_err_evt),
        .o_legal_eop (w_legal_eop),
        .o_err_pulse (o_err_pulse)
    );

    // Statistics next values; a clear overrides a same-cycle increment.
    always_comb begin
        if (i_clr_stats) begin
            w_pkt_cnt_nxt = 16'd0;
            w_err_cnt_nxt = 4'd0;
            w_sticky_nxt  = 1'b0;
        end else begin
            w_pkt_cnt_nxt = w_legal_eop ? (r_pkt_cnt + 16'd1) : r_pkt_cnt;
            w_err_cnt_nxt = w_err_evt ? sat_inc4(r_err_cnt) : r_err_cnt;
            w_sticky_nxt  = w_err_evt ? 1'b1 : r_sticky;
        end
    end

    // Header DW0/DW1 is captured on every accepted SOP beat.
    always_comb begin
        if (w_xfer && i_rx_st_sop) begin
            w_hdr_nxt = i_rx_st_data[HDR_W-1:0];
        end else begin
            w_hdr_nxt = r_hdr;
        end
    end

    // Only the low 60 header bits fit in the probe word.
    assign w_unused_hdr = ^w_hdr_nxt[HDR_W-1:HDR_KEEP_W];

    // Counters, header latch and free-running timestamp.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pkt_cnt <= 16'd0;
            r_err_cnt <= 4'd0;
            r_sticky  <= 1'b0;
            r_hdr     <= 64'd0;
            r_ts      <= {TS_W{1'b0}};
        end else begin
            r_pkt_cnt <= w_pkt_cnt_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_sticky  <= w_sticky_nxt;
            r_hdr     <= w_hdr_nxt;
            r_ts      <= r_ts + {{(TS_W-1){1'b0}}, 1'b1};
        end
    end

    // Probe word assembly from the current beat and post-update status.
    always_comb begin
        w_probe_nxt                      = {PROBE_W{1'b0}};
        w_probe_nxt[DATA_MSB:DATA_LSB]   = i_rx_st_data;
        w_probe_nxt[TS_MSB:TS_LSB]       = r_ts;
        w_probe_nxt[PKT_MSB:PKT_LSB]     = w_pkt_cnt_nxt;
        w_probe_nxt[BEAT_MSB:BEAT_LSB]   = w_beat_nxt;
        w_probe_nxt[SOP_BIT]             = i_rx_st_sop;
        w_probe_nxt[EOP_BIT]             = i_rx_st_eop;
        w_probe_nxt[VALID_BIT]           = i_rx_st_valid;
        w_probe_nxt[READY_BIT]           = i_rx_st_ready;
        w_probe_nxt[XFER_BIT]            = w_xfer;
        w_probe_nxt[STATE_MSB:STATE_LSB] = w_state_nxt;
        w_probe_nxt[STICKY_BIT]          = w_sticky_nxt;
        w_probe_nxt[ERRC_MSB:ERRC_LSB]   = w_err_cnt_nxt;
        w_probe_nxt[HDR_MSB:HDR_LSB]     = w_hdr_nxt[HDR_KEEP_W-1:0];
    end

    // Probe register; freeze holds the last captured word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_probe <= {PROBE_W{1'b0}};
        end else if (!i_freeze) begin
            r_probe <= w_probe_nxt;
        end else begin
            r_probe <= r_probe;
        end
    end

    assign o_probe_data = r_probe;

endmodule

// File: tb/tb_tlp_probe_capture.sv
// Directed bench for tlp_probe_capture: expected probe words and error
// pulses are queued as each beat is driven and checked one edge later.
module tb_tlp_probe_capture;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PKT  = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic         clk;
    logic         rst_n;
    logic [127:0] rx_data;
    logic         sop, eop, valid, ready;
    logic         freeze, clr_stats;
    logic [255:0] probe;
    logic         err_pulse;

    int n_vec  = 0;
    int n_miss = 0;
    int edge_n = 0;

    // Expected post-edge status, written by the directed sequence.
    logic [1:0]  e_st = 2'd0;
    logic [7:0]  e_bt = 8'd0;
    logic [15:0] e_pk = 16'd0;
    logic [3:0]  e_ec = 4'd0;
    logic        e_sk = 1'b0;
    logic [59:0] e_hd = 60'd0;
    logic        e_ep = 1'b0;
    logic [255:0] prev_exp = 256'd0;

    logic [255:0] q_probe[$];
    logic         q_err[$];
    string        q_tag[$];

    tlp_probe_capture dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rx_st_data  (rx_data),
        .i_rx_st_sop   (sop),
        .i_rx_st_eop   (eop),
        .i_rx_st_valid (valid),
        .i_rx_st_ready (ready),
        .i_freeze      (freeze),
        .i_clr_stats   (clr_stats),
        .o_probe_data  (probe),
        .o_err_pulse   (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [255:0] mk(input logic [127:0] d, input logic [31:0] ts,
                                        input logic [15:0] pk, input logic [7:0] bt,
                                        input logic s, input logic e, input logic v, input logic r,
                                        input logic [1:0] st, input logic sk,
                                        input logic [3:0] ec, input logic [59:0] hd);
        return {hd, ec, sk, st, v & r, r, v, e, s, bt, pk, ts, d};
    endfunction

    task automatic check_pop();
        logic [255:0] xp;
        logic         xe;
        string        tg;
        xp = q_probe.pop_front();
        xe = q_err.pop_front();
        tg = q_tag.pop_front();
        n_vec++;
        assert (probe === xp) else begin
            n_miss++;
            $error("FAIL %s probe: observed %h expected %h", tg, probe, xp);
        end
        n_vec++;
        assert (err_pulse === xe) else begin
            n_miss++;
            $error("FAIL %s err_pulse: observed %b expected %b", tg, err_pulse, xe);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic r,
                        input logic s, input logic e, input logic [127:0] d);
        logic [255:0] xp;
        valid   = v;
        ready   = r;
        sop     = s;
        eop     = e;
        rx_data = d;
        if (freeze) xp = prev_exp;
        else        xp = mk(d, 32'(edge_n), e_pk, e_bt, s, e, v, r, e_st, e_sk, e_ec, e_hd);
        prev_exp = xp;
        q_probe.push_back(xp);
        q_err.push_back(e_ep);
        q_tag.push_back(tag);
        @(posedge clk);
        edge_n++;
        #1;
        check_pop();
    endtask

    initial begin
        rst_n = 1'b0; rx_data = 128'd0; sop = 1'b0; eop = 1'b0;
        valid = 1'b0; ready = 1'b0; freeze = 1'b0; clr_stats = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        assert (probe === 256'd0) else begin
            n_miss++; $error("FAIL reset_probe: observed %h expected 0", probe);
        end
        n_vec++;
        assert (err_pulse === 1'b0) else begin
            n_miss++; $error("FAIL reset_err: observed %b expected 0", err_pulse);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;

        // Idle after reset: timestamp only.
        for (int i = 0; i < 10; i++) step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 128'd0);
        n_vec++;
        assert (probe[159:128] === 32'd9) else begin
            n_miss++; $error("FAIL ts_at_10: observed %0d expected 9", probe[159:128]);
        end

        // Legal 3-beat packet.
        e_st = S_PKT; e_bt = 8'd0; e_hd = 60'h000_000F_4000_0001;
        step("p3_b0", 1'b1, 1'b1, 1'b1, 1'b0, {64'hDEAD_BEEF_CAFE_F00D, 64'h0000_000F_4000_0001});
        e_bt = 8'd1;
        step("p3_b1", 1'b1, 1'b1, 1'b0, 1'b0, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        e_st = S_IDLE; e_bt = 8'd2; e_pk = 16'd1;
        step("p3_b2", 1'b1, 1'b1, 1'b0, 1'b1, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000);
        step("p3_after", 1'b0, 1'b0, 1'b0, 1'b0, 128'd0);

        // Beat outside a packet, then recovery via single-beat SOP+EOP.
        e_st = S_ERR; e_ec = 4'd1; e_sk = 1'b1; e_ep = 1'b1;
        step("nosop", 1'b1, 1'b1, 1'b0, 1'b0, 128'h3333);
        e_ep = 1'b0;
        step("nosop_gap", 1'b0, 1'b0, 1'b0, 1'b0, 128'd0);
        e_st = S_IDLE; e_bt = 8'd0; e_hd = 60'h123_4567_89AB_CDEF;
        step("err_single", 1'b1, 1'b1, 1'b1, 1'b1, {64'd0, 64'h0123_4567_89AB_CDEF});

        // SOP stalled by ready=0.
        step("stall0", 1'b1, 1'b0, 1'b1, 1'b0, {64'd0, 64'h0000_0001_0000_0003});
        step("stall1", 1'b1, 1'b0, 1'b1, 1'b0, {64'd0, 64'h0000_0001_0000_0003});
        e_st = S_PKT; e_bt = 8'd0; e_hd = 60'h000_0001_0000_0003;
        step("stall_acc", 1'b1, 1'b1, 1'b1, 1'b0, {64'd0, 64'h0000_0001_0000_0003});
        step("eop_stall", 1'b1, 1'b0, 1'b0, 1'b1, 128'h44);
        e_st = S_IDLE; e_bt = 8'd1; e_pk = 16'd2;
        step("eop_acc", 1'b1, 1'b1, 1'b0, 1'b1, 128'h44);

        // 17 framing errors: counter saturates at 15.
        e_st = S_ERR; e_sk = 1'b1; e_ep = 1'b1;
        for (int i = 0; i < 17; i++) begin
            e_ec = (e_ec == 4'd15) ? 4'd15 : e_ec + 4'd1;
            step("err_sat", 1'b1, 1'b1, 1'b0, 1'b0, {96'd0, 32'(i)});
        end
        n_vec++;
        assert (probe[195:192] === 4'd15) else begin
            n_miss++; $error("FAIL errc_sat: observed %0d expected 15", probe[195:192]);
        end
        e_ep = 1'b0;
        step("err_tail", 1'b0, 1'b0, 1'b0, 1'b0, 128'd0);

        // clr_stats together with a counting EOP.
        e_st = S_PKT; e_bt = 8'd0; e_hd = 60'h0AA_0000_0000_0055;
        step("clr_sop", 1'b1, 1'b1, 1'b1, 1'b0, {64'd0, 64'h00AA_0000_0000_0055});
        clr_stats = 1'b1;
        e_st = S_IDLE; e_bt = 8'd1; e_pk = 16'd0; e_ec = 4'd0; e_sk = 1'b0;
        step("clr_eop", 1'b1, 1'b1, 1'b0, 1'b1, 128'h55);
        clr_stats = 1'b0;

        // Freeze for 5 cycles mid-packet; status keeps moving underneath.
        e_st = S_PKT; e_bt = 8'd0; e_hd = 60'h777;
        step("fz_sop", 1'b1, 1'b1, 1'b1, 1'b0, {64'd0, 64'h777});
        freeze = 1'b1;
        e_bt = 8'd1; step("fz_b1", 1'b1, 1'b1, 1'b0, 1'b0, 128'hA1);
        e_bt = 8'd2; step("fz_b2", 1'b1, 1'b1, 1'b0, 1'b0, 128'hA2);
        e_bt = 8'd3; step("fz_b3", 1'b1, 1'b1, 1'b0, 1'b0, 128'hA3);
        e_st = S_IDLE; e_bt = 8'd4; e_pk = 16'd1;
        step("fz_eop", 1'b1, 1'b1, 1'b0, 1'b1, 128'hA4);
        e_st = S_ERR; e_ec = 4'd1; e_sk = 1'b1; e_ep = 1'b1;
        step("fz_err", 1'b1, 1'b1, 1'b0, 1'b0, 128'hA5);
        freeze = 1'b0; e_ep = 1'b0;
        step("fz_rel", 1'b0, 1'b0, 1'b0, 1'b0, 128'd0);

        // Long packet: beat index saturates at 255.
        e_st = S_PKT; e_bt = 8'd0; e_hd = 60'd0;
        step("sat_sop", 1'b1, 1'b1, 1'b1, 1'b0, 128'd0);
        for (int i = 1; i <= 257; i++) begin
            e_bt = (i > 255) ? 8'd255 : 8'(i);
            step("beat_sat", 1'b1, 1'b1, 1'b0, 1'b0, 128'(i));
        end
        e_st = S_IDLE; e_pk = 16'd2;
        step("sat_eop", 1'b1, 1'b1, 1'b0, 1'b1, 128'd0);

        // Reset in the middle of a packet.
        e_st = S_PKT; e_bt = 8'd0; e_hd = 60'hBEE;
        step("rst_sop", 1'b1, 1'b1, 1'b1, 1'b0, {64'd0, 64'hBEE});
        rst_n = 1'b0; valid = 1'b0; ready = 1'b0; sop = 1'b0; eop = 1'b0;
        #2;
        n_vec++;
        assert (probe === 256'd0) else begin
            n_miss++; $error("FAIL rst_async_probe: observed %h expected 0", probe);
        end
        rst_n = 1'b1; edge_n = 0;
        e_st = S_ERR; e_bt = 8'd0; e_pk = 16'd0; e_ec = 4'd1; e_sk = 1'b1; e_hd = 60'd0; e_ep = 1'b1;
        step("rst_nosop", 1'b1, 1'b1, 1'b0, 1'b0, 128'h99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
